// File: rtl/urv_divide_iter_if.sv
// Execute-stage handshake and operand bundle between the uRV core and the iterative divider.
interface urv_divide_iter_if #(
    parameter int g_width = 32
);
    logic               x_stall_i;
    logic               x_kill_i;
    logic               x_stall_req_o;
    logic               d_valid_i;
    logic               d_is_divide_i;
    logic [2:0]         d_fun_i;
    logic [g_width-1:0] d_rs1_i;
    logic [g_width-1:0] d_rs2_i;
    logic [g_width-1:0] x_rd_o;
    logic               x_busy_o;

    // The divider is the slave; the execute stage is the master.
    modport slave (
        input  x_stall_i, x_kill_i, d_valid_i, d_is_divide_i, d_fun_i, d_rs1_i, d_rs2_i,
        output x_stall_req_o, x_rd_o, x_busy_o
    );

    modport master (
        output x_stall_i, x_kill_i, d_valid_i, d_is_divide_i, d_fun_i, d_rs1_i, d_rs2_i,
        input  x_stall_req_o, x_rd_o, x_busy_o
    );
endinterface

// File: rtl/urv_divide_iter.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU, g_bits_per_cycle quotient bits per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module urv_divide_iter #(
    parameter int g_width          = 32,
    parameter int g_bits_per_cycle = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    urv_divide_iter_if.slave div_if
);

    localparam int N  = g_width / g_bits_per_cycle;
    localparam int CW = $clog2(N + 1);
    localparam logic [g_width-1:0] MIN_VAL = {1'b1, {(g_width-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [g_width-1:0] rem_q, rem_d;
    logic [g_width-1:0] dvd_q, dvd_d;
    logic [g_width-1:0] divisor_q, divisor_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               rem_sel_q, rem_sel_d;
    logic [g_width-1:0] x_rd_q, x_rd_d;

    logic               start;
    logic               op_signed;
    logic               rs1_neg, rs2_neg;
    logic               div_zero, overflow;
    logic               stall_req;
    logic [g_width-1:0] step_rem, step_dvd;
    logic [g_width+1:0] trial;
    logic [g_width-1:0] quo_fix, rem_fix;

    assign start     = div_if.d_valid_i & div_if.d_is_divide_i & ~div_if.x_kill_i & (state_q == S_IDLE);
    assign op_signed = div_if.d_fun_i[2] & ~div_if.d_fun_i[0];
    assign rs1_neg   = op_signed & div_if.d_rs1_i[g_width-1];
    assign rs2_neg   = op_signed & div_if.d_rs2_i[g_width-1];
    assign div_zero  = (div_if.d_rs2_i == '0);
    assign overflow  = op_signed & (div_if.d_rs1_i == MIN_VAL) & (div_if.d_rs2_i == '1);

    // Unrolled restoring steps; the quotient shifts into dvd from the right as the dividend leaves.
    always_comb begin
        step_rem = rem_q;
        step_dvd = dvd_q;
        trial    = '0;
        for (int i = 0; i < g_bits_per_cycle; i++) begin
            trial = {1'b0, step_rem, step_dvd[g_width-1]} - {2'b00, divisor_q};
            // A non-negative difference is below the divisor, so bit g_width is clear as well.
            if (trial[g_width+1:g_width] == 2'b00) begin
                step_rem = trial[g_width-1:0];
                step_dvd = {step_dvd[g_width-2:0], 1'b1};
            end else begin
                step_rem = {step_rem[g_width-2:0], step_dvd[g_width-1]};
                step_dvd = {step_dvd[g_width-2:0], 1'b0};
            end
        end
    end

    assign quo_fix = neg_quo_q ? -dvd_q : dvd_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_sel_d = rem_sel_q;
        x_rd_d    = x_rd_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d     = rs1_neg ? -div_if.d_rs1_i : div_if.d_rs1_i;
                    divisor_d = rs2_neg ? -div_if.d_rs2_i : div_if.d_rs2_i;
                    rem_d     = '0;
                    neg_quo_d = rs1_neg ^ rs2_neg;
                    neg_rem_d = rs1_neg;
                    rem_sel_d = div_if.d_fun_i[1];
                    if (div_zero || overflow) begin
                        if (div_if.d_fun_i[1])
                            x_rd_d = div_zero ? div_if.d_rs1_i : '0;
                        else
                            x_rd_d = div_zero ? '1 : MIN_VAL;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1))
                    state_d = S_FIXUP;
            end
            S_FIXUP: begin
                x_rd_d  = rem_sel_q ? rem_fix : quo_fix;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!div_if.x_stall_i)
                    state_d = S_IDLE;
            end
        endcase

        // A kill abandons whatever is in flight and leaves the last delivered result in place.
        if (div_if.x_kill_i) begin
            state_d = S_IDLE;
            x_rd_d  = x_rd_q;
        end
    end

    always_comb begin
        stall_req = 1'b0;
        if (!rst_i && !div_if.x_kill_i)
            stall_req = start | (state_q == S_BUSY) | (state_q == S_FIXUP);
    end

    // NOTE: datapath registers are reset along with the control state so no X ever reaches x_rd_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            x_rd_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values computed above.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_sel_q <= rem_sel_d;
            x_rd_q    <= x_rd_d;
        end
    end

    assign div_if.x_stall_req_o = stall_req;
    assign div_if.x_rd_o        = x_rd_q;
    assign div_if.x_busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_urv_divide_iter.sv
// Bench for urv_divide_iter: a 1-bit/cycle and a 4-bit/cycle instance share one stimulus bus,
// only the selected one sees d_valid_i; an arithmetic/latency model is compared every cycle.
module tb_urv_divide_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sel = 1'b0;
    logic         d_valid = 1'b0;
    logic         d_is_div = 1'b0;
    logic         x_stall = 1'b0;
    logic         x_kill = 1'b0;
    logic [2:0]   d_fun = 3'b000;
    logic [W-1:0] d_rs1 = '0;
    logic [W-1:0] d_rs2 = '0;

    logic         stall_req;
    logic         busy;
    logic [W-1:0] rd;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    urv_divide_iter_if #(.g_width(W)) if1 ();
    urv_divide_iter_if #(.g_width(W)) if4 ();

    assign if1.x_stall_i     = x_stall;
    assign if1.x_kill_i      = x_kill;
    assign if1.d_valid_i     = d_valid & ~sel;
    assign if1.d_is_divide_i = d_is_div;
    assign if1.d_fun_i       = d_fun;
    assign if1.d_rs1_i       = d_rs1;
    assign if1.d_rs2_i       = d_rs2;

    assign if4.x_stall_i     = x_stall;
    assign if4.x_kill_i      = x_kill;
    assign if4.d_valid_i     = d_valid & sel;
    assign if4.d_is_divide_i = d_is_div;
    assign if4.d_fun_i       = d_fun;
    assign if4.d_rs1_i       = d_rs1;
    assign if4.d_rs2_i       = d_rs2;

    urv_divide_iter #(.g_width(W), .g_bits_per_cycle(1)) u_div1 (
        .clk_i  (clk),
        .rst_i  (rst),
        .div_if (if1.slave)
    );

    urv_divide_iter #(.g_width(W), .g_bits_per_cycle(4)) u_div4 (
        .clk_i  (clk),
        .rst_i  (rst),
        .div_if (if4.slave)
    );

    assign stall_req = sel ? if4.x_stall_req_o : if1.x_stall_req_o;
    assign busy      = sel ? if4.x_busy_o      : if1.x_busy_o;
    assign rd        = sel ? if4.x_rd_o        : if1.x_rd_o;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // RISC-V M-extension semantics straight from the ISA rules, using 64-bit signed arithmetic.
    function automatic logic [W-1:0] ref_result(input logic [2:0] fun, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        longint       sa, sb;
        logic [W-1:0] q, r;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (!fun[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return fun[1] ? r : q;
    endfunction

    function automatic bit is_special(input logic [2:0] fun, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
        return (b == '0) || (!fun[0] && a == 32'h8000_0000 && b == '1);
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Per-cycle model: stall cycles remaining, DONE flag, delivered result per instance.
    initial begin : compare
        bit           m_idle;
        bit           m_done;
        bit           start;
        int           m_left;
        int           n;
        logic [W-1:0] m_res;
        logic [W-1:0] m_rd [2];
        m_idle = 1'b1;
        m_done = 1'b0;
        m_left = 0;
        m_res  = '0;
        m_rd[0] = '0;
        m_rd[1] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_idle  = 1'b1;
                m_done  = 1'b0;
                m_left  = 0;
                m_rd[0] = '0;
                m_rd[1] = '0;
            end
            n     = sel ? W / 4 : W;
            start = !rst && d_valid && d_is_div && !x_kill && m_idle;
            check("cyc_stall_req", W'(stall_req), W'(!rst && !x_kill && (start || m_left > 0)));
            check("cyc_busy", W'(busy), W'(!m_idle));
            check("cyc_rd", rd, m_rd[sel]);
            if (!rst) begin
                if (x_kill) begin
                    m_idle = 1'b1;
                    m_done = 1'b0;
                    m_left = 0;
                end else if (start) begin
                    m_idle = 1'b0;
                    if (is_special(d_fun, d_rs1, d_rs2)) begin
                        m_done     = 1'b1;
                        m_rd[sel]  = ref_result(d_fun, d_rs1, d_rs2);
                    end else begin
                        m_left = n + 1;
                        m_res  = ref_result(d_fun, d_rs1, d_rs2);
                    end
                end else if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done    = 1'b1;
                        m_rd[sel] = m_res;
                    end
                end else if (m_done && !x_stall) begin
                    m_done = 1'b0;
                    m_idle = 1'b1;
                end
            end
        end
    end

    // Issue one divide, hold it like the core does, count stall cycles, optionally stall in DONE.
    task automatic run_op(input logic [2:0] fun, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_rd, input int exp_stalls, input int hold,
                          input string name);
        int n;
        n = 0;
        @(posedge clk); #1;
        d_valid  = 1'b1;
        d_is_div = 1'b1;
        d_fun    = fun;
        d_rs1    = a;
        d_rs2    = b;
        x_stall  = (hold > 0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!stall_req)
                break;
            n++;
            @(posedge clk); #1;
            d_rs1 = $urandom;
            d_rs2 = $urandom;
            d_fun = {1'b1, 2'($urandom)};
        end
        check({name, "_stalls"}, W'(n), W'(exp_stalls));
        check({name, "_rd"}, rd, exp_rd);
        check({name, "_done_busy"}, W'(busy), W'(1));
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk); #1;
            if (k == hold)
                x_stall = 1'b0;
            @(negedge clk);
            check({name, "_hold_rd"}, rd, exp_rd);
            check({name, "_hold_busy"}, W'(busy), W'(1));
        end
        @(posedge clk); #1;
        d_valid  = 1'b0;
        d_is_div = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [W-1:0] saved;
        logic [2:0]   fun;
        logic [W-1:0] a, b;
        int           st;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("model_div_m7_2", ref_result(3'b100, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
        check("model_rem_ovf", ref_result(3'b110, 32'h8000_0000, '1), 0);

        sel = 1'b0;
        run_op(3'b101, 100, 7, 14, 34, 0, "divu_100_7");
        run_op(3'b111, 100, 7, 2, 34, 0, "remu_100_7");
        run_op(3'b100, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 34, 0, "div_m7_2");
        run_op(3'b110, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 34, 0, "rem_m7_2");
        run_op(3'b110, 7, 32'hFFFF_FFFE, 1, 34, 0, "rem_7_m2");
        run_op(3'b101, 32'h1234, 0, 32'hFFFF_FFFF, 1, 0, "divu_by0");
        run_op(3'b111, 32'h1234, 0, 32'h1234, 1, 0, "remu_by0");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 0, "rem_ovf");

        run_op(3'b101, 1000, 3, 333, 34, 3, "divu_stall");
        @(negedge clk);
        check("stall_release_idle", W'(busy), W'(0));

        saved = rd;
        @(posedge clk); #1;
        d_valid  = 1'b1;
        d_is_div = 1'b1;
        d_fun    = 3'b101;
        d_rs1    = 1000;
        d_rs2    = 7;
        repeat (5) @(posedge clk);
        #1 x_kill = 1'b1;
        @(negedge clk);
        check("kill_stall_req", W'(stall_req), W'(0));
        @(posedge clk); #1;
        x_kill   = 1'b0;
        d_valid  = 1'b0;
        d_is_div = 1'b0;
        @(negedge clk);
        check("kill_idle", W'(busy), W'(0));
        check("kill_rd_kept", rd, saved);
        run_op(3'b101, 1000, 7, 142, 34, 0, "divu_after_kill");

        sel = 1'b1;
        run_op(3'b101, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 10, 0, "divu4");

        @(posedge clk); #1;
        d_valid  = 1'b1;
        d_is_div = 1'b1;
        d_fun    = 3'b101;
        d_rs1    = 32'hFFFF_FFFF;
        d_rs2    = 32'h3;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_stall_req", W'(stall_req), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_rd", rd, 0);
        @(posedge clk); #1;
        rst      = 1'b0;
        d_valid  = 1'b0;
        d_is_div = 1'b0;
        run_op(3'b100, 32'hFFFF_FF9C, 7, 32'hFFFF_FFF2, 10, 0, "div4_m100_7");

        for (int i = 0; i < 60; i++) begin
            sel = 1'($urandom);
            fun = {1'b1, 2'($urandom)};
            a   = pick();
            b   = pick();
            st  = is_special(fun, a, b) ? 1 : (sel ? W / 4 + 2 : W + 2);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_op(fun, a, b, ref_result(fun, a, b), st, $urandom_range(0, 2), "rand");
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
